instr_fetch_unit: RTL

Sequential instruction fetch front-end feeding the control unit. Issues word reads to instruction memory from a running PC, buffers in-order responses in a DEPTH-entry FIFO, and presents each instruction with its PC and pre-split opcode/func fields to decode over a valid/ready handshake. Jump/branch resolution redirects the PC, flushes the buffer and discards stale in-flight responses.

---
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and
// the decode-side valid/ready handshake. master = fetch unit, slave = environment.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  func;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc, opcode, func,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc, opcode, func,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential fetch front-end: credit-limited word reads, in-order response FIFO,
// redirect flush with stale-response drop. IFU_BYPASS_EN adds an empty-FIFO bypass.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_b,
  instr_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t          fifo [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, outstanding, drop;
  logic [CW-1:0]   out_nxt, drop_nxt;
  logic [CW:0]     inflight;
  logic [31:0]     fetch_pc, ret_pc, redir_pc;
  logic [0:0]      state;
  logic            req, grant, rv, keep, bypass, push, pop, pop_fifo, valid;

  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  // Credit covers both buffered and in-flight words, so the FIFO cannot overflow.
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign req      = rst_b && !bus.redirect && (inflight < (CW+1)'(DEPTH));
  assign grant    = req && bus.imem_gnt;

  // A response with nothing outstanding belongs to a pre-reset request; ignore it.
  assign rv   = bus.imem_rvalid && (outstanding != '0);
  assign keep = rv && (state == S_RUN) && !bus.redirect;

  assign out_nxt  = outstanding + CW'(grant) - CW'(rv);
  assign drop_nxt = bus.redirect          ? outstanding - CW'(rv) :
                    (rv && drop != '0)    ? drop - CW'(1)         : drop;

`ifdef IFU_BYPASS_EN
  assign bypass = (count == '0) && keep;
  assign head   = (count != '0) ? fifo[rptr] : entry_t'{pc: ret_pc, word: bus.imem_rdata};
`else
  assign bypass = 1'b0;
  assign head   = fifo[rptr];
`endif

  assign valid    = (count != '0) || bypass;
  assign pop      = valid && bus.inst_ready && !bus.redirect;
  assign pop_fifo = pop && (count != '0);
  assign push     = keep && !(bypass && bus.inst_ready);

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? head.word        : '0;
  assign bus.inst_pc    = valid ? head.pc          : '0;
  assign bus.opcode     = valid ? head.word[31:26] : '0;
  assign bus.func       = valid ? head.word[5:0]   : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      state       <= S_RUN;
    end else begin
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      state       <= (drop_nxt != '0) ? S_FLUSH : S_RUN;
      if (bus.redirect) begin
        fetch_pc <= redir_pc;
        ret_pc   <= redir_pc;
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        if (grant)    fetch_pc <= fetch_pc + 32'd4;
        if (keep)     ret_pc   <= ret_pc + 32'd4;
        if (push)     wptr     <= wptr + AW'(1);
        if (pop_fifo) rptr     <= rptr + AW'(1);
        count <= count + CW'(push) - CW'(pop_fifo);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= entry_t'{pc: ret_pc, word: bus.imem_rdata};
  end
endmodule
